// File: rtl/axis_block_mean_subtractor.sv
// Subtracts the per-block average from every sample of that block and emits the
// DATA_WIDTH+1 bit two's-complement residual, flagging the final residual of each block.
module axis_block_mean_subtractor #(
    parameter int DATA_WIDTH        = 16,
    parameter int ELEMENT_COUNT_LOG = 8,
    parameter bit IS_SIGNED         = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_avg_valid,
    output logic                  input_avg_ready,
    input  logic [DATA_WIDTH-1:0] input_avg_data,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH:0]   output_data,
    output logic                  output_last
);

    // A zero-width counter is not legal; with one sample per block the counter stays 0.
    localparam int CNT_W = (ELEMENT_COUNT_LOG > 0) ? ELEMENT_COUNT_LOG : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** ELEMENT_COUNT_LOG) - 1);

    typedef enum logic {
        WAIT_AVG = 1'b0,
        STREAM   = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        counter;
    logic [DATA_WIDTH-1:0]   avg_reg;
    logic                    avg_fire;
    logic                    sample_fire;
    logic                    last_sample;

    function automatic logic signed [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] v);
        if (IS_SIGNED) begin
            return $signed({v[DATA_WIDTH-1], v});
        end
        return $signed({1'b0, v});
    endfunction

    // One extra bit is enough for any difference of two extended operands.
    function automatic logic signed [DATA_WIDTH:0] residual(
        input logic [DATA_WIDTH-1:0] sample,
        input logic [DATA_WIDTH-1:0] avg
    );
        return ext(sample) - ext(avg);
    endfunction

    // Readies are gated by reset so nothing is accepted while the block is held in reset.
    assign input_avg_ready = rst && (state == WAIT_AVG);
    assign input_ready     = rst && (state == STREAM) && (!output_valid || output_ready);

    assign avg_fire    = input_avg_valid && input_avg_ready;
    assign sample_fire = input_valid && input_ready;
    assign last_sample = (counter == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WAIT_AVG;
            counter      <= '0;
            avg_reg      <= '0;
            output_valid <= 1'b0;
            output_data  <= '0;
            output_last  <= 1'b0;
        end else begin
            unique case (state)
                WAIT_AVG: begin
                    if (avg_fire) begin
                        avg_reg <= input_avg_data;
                        counter <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (sample_fire) begin
                        if (last_sample) begin
                            counter <= '0;
                            state   <= WAIT_AVG;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_AVG;
            endcase

            // Output register: loaded on every accepted sample, drained independently of the FSM.
            if (sample_fire) begin
                output_data  <= residual(input_data, avg_reg);
                output_valid <= 1'b1;
                output_last  <= last_sample;
            end else if (output_ready) begin
                output_valid <= 1'b0;
            end
        end
    end

    stall_stable_a : assert property (@(posedge clk) disable iff (!rst)
        output_valid && !output_ready |=> output_valid && $stable(output_data) && $stable(output_last));

endmodule

// File: tb/tb_axis_block_mean_subtractor.sv
// Scoreboard bench: three DUT configurations (unsigned LOG=2, signed LOG=2, unsigned W=8 LOG=0)
// driven by directed and random blocks and checked against an arithmetic reference model.
module tb_axis_block_mean_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  av, iv, orr, hold;
    logic        rnd_mode;
    logic [15:0] ad[3];
    logic [15:0] sd[3];
    wire  [2:0]  ar, ir, ov, ol;
    wire  [16:0] od0, od1;
    wire  [8:0]  od2;

    int total = 0;
    int bad   = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] q2[$];
    logic [17:0] mon_got, mon_exp;

    axis_block_mean_subtractor #(.DATA_WIDTH(16), .ELEMENT_COUNT_LOG(2), .IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst),
        .input_avg_valid(av[0]), .input_avg_ready(ar[0]), .input_avg_data(ad[0]),
        .input_valid(iv[0]), .input_ready(ir[0]), .input_data(sd[0]),
        .output_valid(ov[0]), .output_ready(orr[0]), .output_data(od0), .output_last(ol[0])
    );

    axis_block_mean_subtractor #(.DATA_WIDTH(16), .ELEMENT_COUNT_LOG(2), .IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .input_avg_valid(av[1]), .input_avg_ready(ar[1]), .input_avg_data(ad[1]),
        .input_valid(iv[1]), .input_ready(ir[1]), .input_data(sd[1]),
        .output_valid(ov[1]), .output_ready(orr[1]), .output_data(od1), .output_last(ol[1])
    );

    axis_block_mean_subtractor #(.DATA_WIDTH(8), .ELEMENT_COUNT_LOG(0), .IS_SIGNED(1'b0)) dut_one (
        .clk(clk), .rst(rst),
        .input_avg_valid(av[2]), .input_avg_ready(ar[2]), .input_avg_data(ad[2][7:0]),
        .input_valid(iv[2]), .input_ready(ir[2]), .input_data(sd[2][7:0]),
        .output_valid(ov[2]), .output_ready(orr[2]), .output_data(od2), .output_last(ol[2])
    );

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input longint act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Reference: interpret both operands as integers of the instance's width/signedness,
    // subtract, and keep the low W+1 bits.
    function automatic logic [16:0] resid(input int k, input logic [15:0] s, input logic [15:0] a);
        int     w;
        longint sx, ax, d;
        w  = (k == 2) ? 8 : 16;
        sx = longint'(s);
        ax = longint'(a);
        if (k == 1) begin
            if (s[w-1]) sx -= (longint'(1) << w);
            if (a[w-1]) ax -= (longint'(1) << w);
        end
        d = sx - ax;
        return 17'(d & ((longint'(1) << (w + 1)) - 1));
    endfunction

    task automatic push(input int k, input logic last, input logic [16:0] v);
        case (k)
            0: q0.push_back({last, v});
            1: q1.push_back({last, v});
            default: q2.push_back({last, v});
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop(input int k, output logic [17:0] v);
        case (k)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic send_avg(input int k, input logic [15:0] v);
        int n;
        n     = 0;
        ad[k] = v;
        av[k] = 1'b1;
        forever begin
            @(negedge clk);
            if (ar[k]) break;
            n++;
            if (n > 300) begin
                fail($sformatf("avg_timeout%0d", k), n);
                av[k] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        av[k] = 1'b0;
    endtask

    task automatic send_smp(input int k, input logic [15:0] v);
        int n;
        n     = 0;
        sd[k] = v;
        iv[k] = 1'b1;
        forever begin
            @(negedge clk);
            if (ir[k]) break;
            n++;
            if (n > 300) begin
                fail($sformatf("smp_timeout%0d", k), n);
                iv[k] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic send_block(input int k, input logic [15:0] a, input logic [15:0] s0,
                              input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] s3);
        logic [15:0] s[4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) push(k, i == 3, resid(k, s[i], a));
        send_avg(k, a);
        for (int i = 0; i < 4; i++) send_smp(k, s[i]);
    endtask

    function automatic logic [15:0] pick(input logic [15:0] m);
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return m;
            2: return m >> 1;
            3: return (m >> 1) + 16'd1;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    task automatic gap();
        int g;
        g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_block(input int k);
        int          n;
        logic [15:0] m, a;
        logic [15:0] s[4];
        m = (k == 2) ? 16'h00FF : 16'hFFFF;
        n = (k == 2) ? 1 : 4;
        a = pick(m);
        for (int i = 0; i < n; i++) begin
            s[i] = pick(m);
            push(k, i == n - 1, resid(k, s[i], a));
        end
        gap();
        send_avg(k, a);
        for (int i = 0; i < n; i++) begin
            gap();
            send_smp(k, s[i]);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q0.size() + q1.size() + q2.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 2000) begin
                fail("drain_timeout", q0.size() + q1.size() + q2.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness: random back-pressure in random mode, forced low by hold.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 3; k++)
            orr[k] = hold[k] ? 1'b0 : (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: every output transfer is popped from its scoreboard queue and compared.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && orr[k]) begin
                    mon_got = (k == 0) ? {ol[0], od0} : (k == 1) ? {ol[1], od1} : {ol[2], 8'h00, od2};
                    if (qsize(k) == 0) begin
                        fail($sformatf("unexpected_out%0d", k), mon_got);
                    end else begin
                        pop(k, mon_exp);
                        chk($sformatf("resid%0d", k), mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        av       = '0;
        iv       = '0;
        hold     = '0;
        orr      = 3'b111;
        rnd_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ad[k] = '0;
            sd[k] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_data", od0, 0);
        chk("rst_last", ol, 0);
        chk("rst_in_ready", ir, 0);
        chk("rst_avg_ready", ar, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_avg_ready", ar, 3'b111);
        chk("idle_in_ready", ir, 0);
        @(posedge clk);
        #1;

        // Basic block: residuals 0x1FFFE, 0, 2, 5 with last on the final one.
        send_block(0, 16'd10, 16'd8, 16'd10, 16'd12, 16'd15);
        wait_drain();

        // Downstream stall mid-block holds the residual and blocks input_ready.
        for (int i = 0; i < 4; i++)
            push(0, i == 3, resid(0, 16'(8 + 2 * i), 16'd10));
        send_avg(0, 16'd10);
        send_smp(0, 16'd8);
        send_smp(0, 16'd10);
        hold[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", ov[0], 1);
            chk("stall_in_ready", ir[0], 0);
            chk("stall_data", od0, resid(0, 16'd10, 16'd10));
            chk("stall_last", ol[0], 0);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
        send_smp(0, 16'd12);
        send_smp(0, 16'd14);
        wait_drain();

        // Samples offered before their average are held off.
        push(0, 1'b0, resid(0, 16'd25, 16'd20));
        push(0, 1'b0, resid(0, 16'd20, 16'd20));
        push(0, 1'b0, resid(0, 16'd3, 16'd20));
        push(0, 1'b1, resid(0, 16'd100, 16'd20));
        fork
            begin
                send_smp(0, 16'd25);
                send_smp(0, 16'd20);
                send_smp(0, 16'd3);
                send_smp(0, 16'd100);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("early_in_ready", ir[0], 0);
                    chk("early_valid", ov[0], 0);
                end
                @(posedge clk);
                #1;
                send_avg(0, 16'd20);
            end
        join
        wait_drain();

        // Extremes of the unsigned range and the signed range.
        send_block(0, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF);
        send_block(0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000);
        send_block(1, 16'hFFFD, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFD);
        for (int i = 0; i < 4; i++) rand_block(2);
        wait_drain();

        // Reset in mid-block discards the stalled residual; next block starts fresh.
        push(0, 1'b0, resid(0, 16'h0030, 16'h0005));
        send_avg(0, 16'h0005);
        send_smp(0, 16'h0030);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (q0.size() == 0) break;
        end
        #1;
        hold[0] = 1'b1;
        send_smp(0, 16'h0040);
        @(negedge clk);
        chk("pre_rst_valid", ov[0], 1);
        rst = 1'b0;
        #1;
        chk("arst_valid", ov[0], 0);
        chk("arst_data", od0, 0);
        chk("arst_last", ol[0], 0);
        chk("arst_in_ready", ir[0], 0);
        chk("arst_avg_ready", ar[0], 0);
        @(negedge clk);
        rst     = 1'b1;
        hold[0] = 1'b0;
        @(posedge clk);
        #1;
        send_block(0, 16'd7, 16'd1, 16'd2, 16'd3, 16'd4);
        wait_drain();

        // Random blocks on all three instances with random back-pressure.
        rnd_mode = 1'b1;
        fork
            repeat (12) rand_block(0);
            repeat (12) rand_block(1);
            repeat (30) rand_block(2);
        join
        rnd_mode = 1'b0;
        wait_drain();
        repeat (5) @(posedge clk);
        chk("final_queue", q0.size() + q1.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
